// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle between the 5-stage datapath and pipe_hazard_ctrl.
// The master side is the datapath and memory; the slave side is the controller.
interface pipe_hazard_ctrl_if;
  logic [4:0]  RsD, RtD, RsE, RtE;
  logic [4:0]  WriteRegE, WriteRegM, WriteRegW;
  logic        RegWriteE, RegWriteM, RegWriteW;
  logic        MemtoRegE, MemtoRegM, MemWriteM;
  logic        BranchD, PCSrcD;
  logic        dmem_ack, dmem_req;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        ForwardAD, ForwardBD;
  logic        StallF, StallD, StallE, StallM;
  logic        FlushD, FlushE, FlushW;
  logic        mem_err;
  logic [31:0] perf_stall, perf_flush;

  modport master (
    output RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
           RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, MemWriteM,
           BranchD, PCSrcD, dmem_ack,
    input  dmem_req, ForwardAE, ForwardBE, ForwardAD, ForwardBD,
           StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           mem_err, perf_stall, perf_flush
  );

  modport slave (
    input  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
           RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, MemWriteM,
           BranchD, PCSrcD, dmem_ack,
    output dmem_req, ForwardAE, ForwardBE, ForwardAD, ForwardBD,
           StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           mem_err, perf_stall, perf_flush
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Forwarding, load-use/branch stall and data-memory freeze controller for the 5-stage pipe.
// Optional stall/flush counters are built when PIPE_HAZARD_CTRL_PERF_EN is defined.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  pipe_hazard_ctrl_if.slave hz
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MEM_TIMEOUT);

  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_WAIT = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          mem_err_q, mem_err_d;
  logic          memop_s, memstall_s, lwstall_s, brstall_s, hazard_s;

  function automatic logic fwd_hit(input logic we, input logic [4:0] wr, input logic [4:0] src);
    return we && (wr != 5'd0) && (wr == src);
  endfunction

  // Operand forwarding: M beats W, register 0 never forwards.
  always_comb begin
    hz.ForwardAE = 2'b00;
    hz.ForwardBE = 2'b00;
    if (fwd_hit(hz.RegWriteM, hz.WriteRegM, hz.RsE)) begin
      hz.ForwardAE = 2'b10;
    end else if (fwd_hit(hz.RegWriteW, hz.WriteRegW, hz.RsE)) begin
      hz.ForwardAE = 2'b01;
    end else begin
      hz.ForwardAE = 2'b00;
    end
    if (fwd_hit(hz.RegWriteM, hz.WriteRegM, hz.RtE)) begin
      hz.ForwardBE = 2'b10;
    end else if (fwd_hit(hz.RegWriteW, hz.WriteRegW, hz.RtE)) begin
      hz.ForwardBE = 2'b01;
    end else begin
      hz.ForwardBE = 2'b00;
    end
    hz.ForwardAD = fwd_hit(hz.RegWriteM, hz.WriteRegM, hz.RsD);
    hz.ForwardBD = fwd_hit(hz.RegWriteM, hz.WriteRegM, hz.RtD);
  end

  // Stall/flush decode; an outstanding memory access overrides every other hazard.
  always_comb begin
    memop_s    = hz.MemtoRegM || hz.MemWriteM;
    memstall_s = memop_s && !hz.dmem_ack;
    lwstall_s  = hz.MemtoRegE && ((hz.RtE == hz.RsD) || (hz.RtE == hz.RtD));
    brstall_s  = hz.BranchD &&
                 ((hz.RegWriteE && (hz.WriteRegE != 5'd0) &&
                   ((hz.WriteRegE == hz.RsD) || (hz.WriteRegE == hz.RtD))) ||
                  (hz.MemtoRegM && (hz.WriteRegM != 5'd0) &&
                   ((hz.WriteRegM == hz.RsD) || (hz.WriteRegM == hz.RtD))));
    hazard_s   = lwstall_s || brstall_s;
    hz.dmem_req = memop_s;
    if (memstall_s) begin
      hz.StallF = 1'b1;
      hz.StallD = 1'b1;
      hz.StallE = 1'b1;
      hz.StallM = 1'b1;
      hz.FlushD = 1'b0;
      hz.FlushE = 1'b0;
      hz.FlushW = 1'b1;
    end else begin
      hz.StallF = hazard_s;
      hz.StallD = hazard_s;
      hz.StallE = 1'b0;
      hz.StallM = 1'b0;
      hz.FlushD = hz.PCSrcD && !hazard_s;
      hz.FlushE = hazard_s;
      hz.FlushW = 1'b0;
    end
  end

  // Memory FSM next state, wait counter and sticky timeout flag.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    case (state_q)
      ST_RUN: begin
        if (memstall_s) begin
          state_d    = ST_WAIT;
          wait_cnt_d = {CW{1'b0}};
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_WAIT: begin
        // A vanished memop can only come from a control glitch; leave WAIT rather than hang.
        if (hz.dmem_ack || !memop_s) begin
          state_d = ST_RUN;
        end else if (wait_cnt_q != CNT_MAX) begin
          state_d    = ST_WAIT;
          wait_cnt_d = wait_cnt_q + CW'(1);
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = {CW{1'b0}};
      end
    endcase
    if (wait_cnt_d == CNT_MAX) begin
      mem_err_d = 1'b1;
    end else begin
      mem_err_d = mem_err_q;
    end
  end

  // FSM, counter and error registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= {CW{1'b0}};
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  assign hz.mem_err = mem_err_q;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  // Saturating event counters.
  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_flush_d = perf_flush_q;
    if (hz.StallF && (perf_stall_q != 32'hFFFF_FFFF)) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end else begin
      perf_stall_d = perf_stall_q;
    end
    if ((hz.FlushD || hz.FlushE) && (perf_flush_q != 32'hFFFF_FFFF)) begin
      perf_flush_d = perf_flush_q + 32'd1;
    end else begin
      perf_flush_d = perf_flush_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_stall_q <= 32'd0;
      perf_flush_q <= 32'd0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign hz.perf_stall = perf_stall_q;
  assign hz.perf_flush = perf_flush_q;
`else
  assign hz.perf_stall = 32'd0;
  assign hz.perf_flush = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a table of single-cycle vectors plus
// hand-written memory-wait, timeout, reset and counter sequences.
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if hz();
  pipe_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (.clk(clk), .rst_n(rst_n), .hz(hz));

  // ctl = {RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, MemWriteM, BranchD, PCSrcD, dmem_ack}
  // exp = {ForwardAE, ForwardBE, ForwardAD, ForwardBD, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, dmem_req}
  typedef struct packed {
    logic [4:0]  rsd, rtd, rse, rte, wre, wrm, wrw;
    logic [8:0]  ctl;
    logic [13:0] exp;
  } vec_t;

  localparam logic [31:0] ST_RUN  = 32'd0;
  localparam logic [31:0] ST_WAIT = 32'd1;
  localparam logic [13:0] O_NONE  = 14'b00_00_0_0_0_0_0_0_0_0_0_0;
  localparam logic [13:0] O_HAZ   = 14'b00_00_0_0_1_1_0_0_0_1_0_0;
  localparam logic [13:0] O_MEMST = 14'b00_00_0_0_1_1_1_1_0_0_1_1;
  localparam logic [13:0] O_REQ   = 14'b00_00_0_0_0_0_0_0_0_0_0_1;

  vec_t tv [0:15];
  int   nv = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  logic [13:0] outs_s;
  logic [31:0] exp_ps, exp_pf;

  assign outs_s = {hz.ForwardAE, hz.ForwardBE, hz.ForwardAD, hz.ForwardBD,
                   hz.StallF, hz.StallD, hz.StallE, hz.StallM,
                   hz.FlushD, hz.FlushE, hz.FlushW, hz.dmem_req};

  task automatic drive(input logic [4:0] rsd, input logic [4:0] rtd, input logic [4:0] rse,
                       input logic [4:0] rte, input logic [4:0] wre, input logic [4:0] wrm,
                       input logic [4:0] wrw, input logic [8:0] ctl);
    hz.RsD = rsd; hz.RtD = rtd; hz.RsE = rse; hz.RtE = rte;
    hz.WriteRegE = wre; hz.WriteRegM = wrm; hz.WriteRegW = wrw;
    {hz.RegWriteE, hz.RegWriteM, hz.RegWriteW, hz.MemtoRegE, hz.MemtoRegM,
     hz.MemWriteM, hz.BranchD, hz.PCSrcD, hz.dmem_ack} = ctl;
    #1;
  endtask

  task automatic idle();
    drive(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 9'b000_000_000);
  endtask

  task automatic add(input logic [4:0] rsd, input logic [4:0] rtd, input logic [4:0] rse,
                     input logic [4:0] rte, input logic [4:0] wre, input logic [4:0] wrm,
                     input logic [4:0] wrw, input logic [8:0] ctl, input logic [13:0] exp);
    tv[nv] = {rsd, rtd, rse, rte, wre, wrm, wrw, ctl, exp};
    nv++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    tick();
    tick();
    chk("rst_outs", 32'(outs_s), 32'(O_NONE));
    chk("rst_err", 32'(hz.mem_err), 32'd0);
    chk("rst_state", 32'(dut.state_q), ST_RUN);
    chk("rst_pstall", hz.perf_stall, 32'd0);
    chk("rst_pflush", hz.perf_flush, 32'd0);
    rst_n = 1'b1;

    add(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 9'b000_000_000, O_NONE);
    add(5'd0, 5'd0, 5'd8, 5'd0, 5'd0, 5'd8, 5'd8, 9'b011_000_000, 14'b10_00_0_0_0_0_0_0_0_0_0_0);
    add(5'd0, 5'd0, 5'd8, 5'd0, 5'd0, 5'd0, 5'd8, 9'b011_000_000, 14'b01_00_0_0_0_0_0_0_0_0_0_0);
    add(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 9'b011_000_000, O_NONE);
    add(5'd0, 5'd0, 5'd0, 5'd3, 5'd0, 5'd3, 5'd3, 9'b011_000_000, 14'b00_10_0_0_0_0_0_0_0_0_0_0);
    add(5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 9'b001_000_000, 14'b00_01_0_0_0_0_0_0_0_0_0_0);
    add(5'd0, 5'd0, 5'd4, 5'd0, 5'd0, 5'd4, 5'd0, 9'b000_000_000, O_NONE);
    add(5'd6, 5'd6, 5'd0, 5'd0, 5'd0, 5'd6, 5'd0, 9'b010_000_000, 14'b00_00_1_1_0_0_0_0_0_0_0_0);
    add(5'd5, 5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd0, 9'b000_100_010, O_HAZ);
    add(5'd3, 5'd2, 5'd0, 5'd2, 5'd0, 5'd0, 5'd0, 9'b000_100_000, O_HAZ);
    add(5'd3, 5'd4, 5'd0, 5'd2, 5'd0, 5'd0, 5'd0, 9'b000_100_000, O_NONE);
    add(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 9'b000_000_010, 14'b00_00_0_0_0_0_0_0_1_0_0_0);
    add(5'd9, 5'd0, 5'd0, 5'd0, 5'd9, 5'd0, 5'd0, 9'b100_000_110, O_HAZ);
    add(5'd0, 5'd4, 5'd0, 5'd0, 5'd0, 5'd4, 5'd0, 9'b000_010_101, 14'b00_00_0_0_1_1_0_0_0_1_0_1);
    add(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 9'b100_000_100, O_NONE);
    add(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 9'b000_001_001, O_REQ);

    for (int i = 0; i < nv; i++) begin
      drive(tv[i].rsd, tv[i].rtd, tv[i].rse, tv[i].rte, tv[i].wre, tv[i].wrm, tv[i].wrw, tv[i].ctl);
      chk($sformatf("vec%0d", i), 32'(outs_s), 32'(tv[i].exp));
      tick();
    end

    // Branch waits on the E producer, then takes it by forwarding from M.
    drive(5'd9, 5'd0, 5'd0, 5'd0, 5'd9, 5'd0, 5'd0, 9'b100_000_100);
    chk("br_stall", 32'(outs_s), 32'(O_HAZ));
    tick();
    drive(5'd9, 5'd0, 5'd0, 5'd0, 5'd0, 5'd9, 5'd0, 9'b010_000_100);
    chk("br_fwd", 32'(outs_s), 32'(14'b00_00_1_0_0_0_0_0_0_0_0_0));
    tick();

    rst_n = 1'b0;
    idle();
    tick();
    rst_n = 1'b1;

    // Three-cycle memory wait; PCSrcD in the first cycle must not flush.
    for (int i = 0; i < 3; i++) begin
      drive(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, (i == 0) ? 9'b000_010_010 : 9'b000_010_000);
      chk($sformatf("mw_c%0d", i), 32'(outs_s), 32'(O_MEMST));
      chk($sformatf("mw_st%0d", i), 32'(dut.state_q), (i == 0) ? ST_RUN : ST_WAIT);
      tick();
    end
    drive(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 9'b000_010_001);
    chk("mw_ack", 32'(outs_s), 32'(O_REQ));
    chk("mw_ack_st", 32'(dut.state_q), ST_WAIT);
    tick();
    idle();
    chk("mw_rel_st", 32'(dut.state_q), ST_RUN);
    chk("mw_rel", 32'(outs_s), 32'(O_NONE));
    chk("mw_err", 32'(hz.mem_err), 32'd0);
    tick();

    // One load-use stall, released when the bubble reaches E.
    drive(5'd5, 5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd0, 9'b000_100_000);
    chk("lu_stall", 32'(outs_s), 32'(O_HAZ));
    tick();
    idle();
    chk("lu_rel", 32'(outs_s), 32'(O_NONE));
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    exp_ps = 32'd4;
    exp_pf = 32'd1;
`else
    exp_ps = 32'd0;
    exp_pf = 32'd0;
`endif
    chk("perf_stall", hz.perf_stall, exp_ps);
    chk("perf_flush", hz.perf_flush, exp_pf);
    tick();

    // Timeout: one RUN cycle then WAIT cycles; error rises after the fourth.
    for (int k = 1; k <= 5; k++) begin
      drive(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 9'b000_010_000);
      tick();
      chk($sformatf("to_err%0d", k), 32'(hz.mem_err), (k == 5) ? 32'd1 : 32'd0);
    end
    tick();
    tick();
    chk("to_sticky", 32'(hz.mem_err), 32'd1);
    chk("to_frozen", 32'(outs_s), 32'(O_MEMST));
    chk("to_state", 32'(dut.state_q), ST_WAIT);

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rr_err", 32'(hz.mem_err), 32'd0);
    chk("rr_state", 32'(dut.state_q), ST_RUN);
    chk("rr_req", 32'(hz.dmem_req), 32'd1);
    chk("rr_pstall", hz.perf_stall, 32'd0);
    idle();
    tick();
    chk("rr_idle_st", 32'(dut.state_q), ST_RUN);
    chk("rr_idle", 32'(outs_s), 32'(O_NONE));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard, forwarding and memory-stall controller for the 5-stage pipeline. It watches register addresses and control bits in the D/E/M/W stages and drives forwarding selects, stalls and flushes for the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It also runs a req/ack handshake with a variable-latency data memory and freezes the pipeline while an access is outstanding.

## Interface
- MEM_TIMEOUT, 64: WAIT cycles before mem_err is raised (≥2).
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- RsD, RtD, RsE, RtE  in  5 each  source register numbers in D and E.
- WriteRegE, WriteRegM, WriteRegW  in  5 each  destination register numbers.
- RegWriteE, RegWriteM, RegWriteW  in  1 each  stage writes the register file.
- MemtoRegE, MemtoRegM, MemWriteM  in  1 each  load in E/M; store in M.
- BranchD  in  1  branch or jr resolved in D.
- PCSrcD  in  1  branch or jump taken in D.
- dmem_ack  in  1  data memory completes the access this cycle.
- dmem_req  out  1  data memory access request.
- ForwardAE, ForwardBE  out  2 each  EX operand select: 00 regfile, 01 W result, 10 M ALUOut.
- ForwardAD, ForwardBD  out  1 each  forward M ALUOut to the D comparator.
- StallF, StallD, StallE, StallM  out  1 each  hold PC, IF/ID, ID/EX, EX/MEM.
- FlushD, FlushE, FlushW  out  1 each  bubble IF/ID, ID/EX, MEM/WB.
- mem_err  out  1  sticky timeout flag.
- perf_stall, perf_flush  out  32 each  performance counters.

## Operation
- FSM state: RUN or WAIT. wait_cnt is a counter of $clog2(MEM_TIMEOUT+1) bits.
- Forwarding (combinational):
  - ForwardAE = 10 if RegWriteM && WriteRegM!=0 && WriteRegM==RsE.
  - Otherwise ForwardAE = 01 if RegWriteW && WriteRegW!=0 && WriteRegW==RsE.
  - Otherwise ForwardAE = 00. ForwardBE follows the same rule on RtE.
  - ForwardAD/BD = RegWriteM && WriteRegM!=0 && WriteRegM==RsD/RtD.
  - Forwarding outputs are never gated by stall or reset.
- lwstall = MemtoRegE && (RtE==RsD || RtE==RtD).
- brstall: BranchD, and either
  - RegWriteE && WriteRegE!=0 && WriteRegE matches RsD or RtD, or
  - MemtoRegM && WriteRegM!=0 && WriteRegM matches RsD or RtD.
- memop = MemtoRegM || MemWriteM. dmem_req = memop, in both states.
- memstall = memop && !dmem_ack.
- When memstall = 1:
  - StallF = StallD = StallE = StallM = 1 and FlushW = 1.
  - FlushD = FlushE = 0; lwstall, brstall and PCSrcD are ignored and re-evaluated after release.
- When memstall = 0:
  - StallF = StallD = lwstall || brstall.
  - FlushE = lwstall || brstall.
  - FlushD = PCSrcD && !(lwstall || brstall).
  - StallE = StallM = FlushW = 0.
- Transitions:
  - RUN→WAIT on memstall.
  - WAIT→RUN on dmem_ack.
  - WAIT→RUN on a cycle with memop = 0, which only a reset-free control glitch can produce; this is defensive.
  - wait_cnt clears on entry to WAIT and increments each WAIT cycle, saturating at MEM_TIMEOUT.
  - When wait_cnt reaches MEM_TIMEOUT, mem_err sets and stays set until reset. The state remains WAIT and the pipeline stays frozen.
- Reset (rst_n=0 at a rising edge):
  - State→RUN, wait_cnt→0, mem_err→0, perf counters→0.
  - This applies mid-WAIT too: dmem_req re-evaluates from memop the next cycle.

## Timing
- All stall, flush and forward outputs are combinational from the inputs and state; zero-cycle latency. dmem_req is combinational from memop.
- A zero-wait access (ack in the same cycle as req) causes no stall.
- A stall is released in the same cycle ack arrives. The EX/MEM register advances at that edge, and the state is RUN on the next cycle.
- Back-to-back memory ops: the next op in M raises dmem_req in the cycle after release.
- mem_err rises at the edge after MEM_TIMEOUT consecutive WAIT cycles.
- Output values right after reset: state RUN and mem_err = 0. With all inputs at 0, every stall, flush and forward output and dmem_req is 0.

## Configuration
- Macro: PIPE_HAZARD_CTRL_PERF_EN.
- Defined:
  - perf_stall increments on every cycle where StallF = 1.
  - perf_flush increments on every cycle where FlushD or FlushE is 1.
  - Both saturate at 32'hFFFF_FFFF and clear on reset.
- Undefined: the ports still exist, are tied to 0, and no counter flops are built.

## Test plan
- Forwarding: RegWriteM=1, WriteRegM=8, RegWriteW=1, WriteRegW=8, RsE=8 → ForwardAE=10. Then WriteRegM=0 → ForwardAE=01. Then RsE=0 with W matching register 0 → ForwardAE=00.
- Load-use: MemtoRegE=1, RtE=5, RsD=5, PCSrcD=1 → StallF=StallD=FlushE=1 and FlushD=0, for exactly one cycle.
- Branch hazard: BranchD=1, RsD=9, RegWriteE=1, WriteRegE=9 → stall plus FlushE. Next cycle, with the producer in M, ForwardAD=1 and no stall.
- Memory wait: MemtoRegM=1, ack held low 3 cycles then high → StallF/D/E/M and FlushW high 3 cycles and low on the ack cycle; state WAIT→RUN; mem_err=0.
- Timeout and reset: MEM_TIMEOUT=4, ack never arrives → mem_err=1 after 4 WAIT cycles and the pipeline stays stalled. Pulse rst_n low 1 cycle → mem_err=0 and state RUN.
- Perf (with macro): 3-cycle memory wait plus one load-use stall → perf_stall=4 and perf_flush=1. Without the macro, both read 0.
